// File: rtl/sipo_pkg.sv
// Shared constants for the serial-in/parallel-out receiver: FSM encoding,
// shift direction names and the counter width helper.
package sipo_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam string DIR_LEFT  = "LEFT";
  localparam string DIR_RIGHT = "RIGHT";

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register plus bit counter. Flags the edge at which a word completes and
// presents that word combinationally so the caller can capture it on the same edge.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter bit SHIFT_LEFT = 1'b1,
  localparam int CW = clog2(WORD_WIDTH + 1)
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  sclr,
  input  logic                  shift_en,
  input  logic                  restart,
  input  logic                  shiftin,
  output logic [WORD_WIDTH-1:0] word,
  output logic [CW-1:0]         count,
  output logic                  done
);

  logic [WORD_WIDTH-1:0] sr_q;
  logic [WORD_WIDTH-1:0] sr_base;
  logic [WORD_WIDTH-1:0] sr_d;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_inc;

  // A restart discards the partial word so no stale bits leak into the new one.
  assign sr_base = restart ? '0 : sr_q;

  generate
    if (WORD_WIDTH == 1) begin : g_single
      assign sr_d = shiftin;
    end else if (SHIFT_LEFT) begin : g_left
      assign sr_d = {sr_base[WORD_WIDTH-2:0], shiftin};
    end else begin : g_right
      assign sr_d = {shiftin, sr_base[WORD_WIDTH-1:1]};
    end
  endgenerate

  assign count_inc = restart ? CW'(1) : count_q + CW'(1);
  assign done      = shift_en && (count_inc == CW'(WORD_WIDTH));
  assign word      = sr_d;
  assign count     = count_q;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      sr_q    <= '0;
      count_q <= '0;
    end else if (sclr) begin
      sr_q    <= '0;
      count_q <= '0;
    end else if (shift_en) begin
      sr_q    <= sr_d;
      count_q <= done ? '0 : count_inc;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Framed serial receiver: IDLE/SHIFT FSM, 1-deep valid/ready output buffer and
// sticky overrun / framing-error flags around the shift core.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int    WORD_WIDTH      = 8,
  parameter string SHIFT_DIRECTION = "LEFT",
  localparam int   CW              = clog2(WORD_WIDTH + 1)
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  sclr,
  input  logic                  enable,
  input  logic                  shiftin,
  input  logic                  frame,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic [CW-1:0]         bit_count,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam bit SHIFT_LEFT = (SHIFT_DIRECTION != DIR_RIGHT);

  logic [0:0]            state_q,   state_d;
  logic [WORD_WIDTH-1:0] data_q,    data_d;
  logic                  valid_q,   valid_d;
  logic                  overrun_q, overrun_d;
  logic                  ferr_q,    ferr_d;

  logic                  shift_en;
  logic                  restart;
  logic [WORD_WIDTH-1:0] core_word;
  logic                  core_done;

  // In IDLE only a framed bit is accepted; in SHIFT every strobed bit is.
  assign shift_en = enable && (frame || (state_q == ST_SHIFT));
  assign restart  = enable && frame;

  sipo_shift_core #(
    .WORD_WIDTH (WORD_WIDTH),
    .SHIFT_LEFT (SHIFT_LEFT)
  ) u_core (
    .clock    (clock),
    .aclr     (aclr),
    .sclr     (sclr),
    .shift_en (shift_en),
    .restart  (restart),
    .shiftin  (shiftin),
    .word     (core_word),
    .count    (bit_count),
    .done     (core_done)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    ferr_d    = ferr_q;

    if (shift_en) begin
      state_d = core_done ? ST_IDLE : ST_SHIFT;
    end
    if (enable && frame && (state_q == ST_SHIFT)) begin
      ferr_d = 1'b1;
    end

    // A completing word may replace a word being consumed on the same edge.
    if (core_done) begin
      if (!valid_q || out_ready) begin
        data_d  = core_word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else if (sclr) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == ST_SHIFT);
  assign overrun   = overrun_q;
  assign frame_err = ferr_q;

endmodule
